// File: rtl/gradient_accumulator.sv
// Per-row signed saturating gradient accumulator that drains every layer/row entry as an update stream.
// Optional build macro GRAD_AVERAGE_EN: emitted rows are divided by batch_size (arithmetic shift, floor).
module gradient_accumulator #(
  parameter int data_size  = 16,
  parameter int size       = 3,
  parameter int layer_size = 5,
  parameter int batch_size = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        is_grad,
  input  logic [31:0]                 grad_layer_index,
  input  logic [31:0]                 grad_row_index,
  input  logic [data_size*size-1:0]   grad,
  input  logic                        is_sample_done,
  input  logic                        is_flush,
  output logic                        is_ready,
  output logic [31:0]                 layer_index,
  output logic [31:0]                 row_index,
  output logic [data_size*size-1:0]   dc_dw,
  output logic                        is_update,
  output logic [31:0]                 sample_count
);

  localparam int ROW_W   = data_size * size;
  localparam int ENTRIES = layer_size * size;
  localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  localparam logic [31:0]      SIZE_U     = 32'(size);
  localparam logic [31:0]      LAYERS_U   = 32'(layer_size);
  localparam logic [31:0]      BATCH_U    = 32'(batch_size);
  localparam logic [31:0]      LAST_LAYER = 32'(layer_size - 1);
  localparam logic [31:0]      LAST_ROW   = 32'(size - 1);
  localparam logic [IDX_W-1:0] SIZE_I     = IDX_W'(size);

  localparam logic [data_size-1:0] ELEM_MAX = {1'b0, {(data_size-1){1'b1}}};
  localparam logic [data_size-1:0] ELEM_MIN = {1'b1, {(data_size-1){1'b0}}};

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Two's complement add with one guard bit; differing top bits mean overflow.
  function automatic logic [data_size-1:0] sat_add(input logic [data_size-1:0] a,
                                                   input logic [data_size-1:0] b);
    logic [data_size:0] sum;
    sum = {a[data_size-1], a} + {b[data_size-1], b};
    if (sum[data_size] != sum[data_size-1]) begin
      return sum[data_size] ? ELEM_MIN : ELEM_MAX;
    end
    return sum[data_size-1:0];
  endfunction

  function automatic logic [ROW_W-1:0] add_row(input logic [ROW_W-1:0] acc,
                                               input logic [ROW_W-1:0] inc);
    logic [ROW_W-1:0] res;
    res = '0;
    for (int i = 0; i < size; i++) begin
      res[i*data_size +: data_size] = sat_add(acc[i*data_size +: data_size],
                                              inc[i*data_size +: data_size]);
    end
    return res;
  endfunction

`ifdef GRAD_AVERAGE_EN
  localparam int SHIFT = $clog2(batch_size);

  // Partial (flushed) batches are still divided by the full batch size.
  function automatic logic [ROW_W-1:0] emit_row(input logic [ROW_W-1:0] acc);
    logic [ROW_W-1:0] res;
    res = '0;
    for (int i = 0; i < size; i++) begin
      res[i*data_size +: data_size] = $signed(acc[i*data_size +: data_size]) >>> SHIFT;
    end
    return res;
  endfunction
`else
  function automatic logic [ROW_W-1:0] emit_row(input logic [ROW_W-1:0] acc);
    return acc;
  endfunction
`endif

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   entries_q [ENTRIES];
  logic [ROW_W-1:0]   entries_d [ENTRIES];
  logic [31:0]        sample_count_q, sample_count_d;
  logic [31:0]        drain_layer_q, drain_layer_d;
  logic [31:0]        drain_row_q, drain_row_d;
  logic [IDX_W-1:0]   drain_idx_q, drain_idx_d;
  logic [31:0]        layer_index_q, layer_index_d;
  logic [31:0]        row_index_q, row_index_d;
  logic [ROW_W-1:0]   dc_dw_q, dc_dw_d;
  logic               is_update_q, is_update_d;

  logic               grad_in_range;
  logic [IDX_W-1:0]   grad_idx;
  logic [31:0]        sample_inc;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves one unassigned (no latches).
    state_d        = state_q;
    entries_d      = entries_q;
    sample_count_d = sample_count_q;
    drain_layer_d  = drain_layer_q;
    drain_row_d    = drain_row_q;
    drain_idx_d    = drain_idx_q;
    layer_index_d  = layer_index_q;
    row_index_d    = row_index_q;
    dc_dw_d        = dc_dw_q;
    is_update_d    = 1'b0;

    grad_in_range = (grad_layer_index < LAYERS_U) && (grad_row_index < SIZE_U);
    // Exact in IDX_W bits whenever the row is in range.
    grad_idx      = grad_layer_index[IDX_W-1:0] * SIZE_I + grad_row_index[IDX_W-1:0];
    sample_inc    = sample_count_q + {31'b0, is_sample_done};

    case (state_q)
      ACCUM: begin
        if (is_grad && grad_in_range) begin
          entries_d[grad_idx] = add_row(entries_q[grad_idx], grad);
        end

        // A completing sample is counted before any flush is considered.
        if (is_sample_done && (sample_inc == BATCH_U)) begin
          state_d        = DRAIN;
          sample_count_d = '0;
        end else if (is_flush && (sample_inc != 32'd0)) begin
          state_d        = DRAIN;
          sample_count_d = '0;
        end else begin
          sample_count_d = sample_inc;
        end
      end

      DRAIN: begin
        layer_index_d          = drain_layer_q;
        row_index_d            = drain_row_q;
        dc_dw_d                = emit_row(entries_q[drain_idx_q]);
        is_update_d            = 1'b1;
        entries_d[drain_idx_q] = '0;

        if (drain_row_q == LAST_ROW) begin
          drain_row_d = '0;
          if (drain_layer_q == LAST_LAYER) begin
            drain_layer_d = '0;
            drain_idx_d   = '0;
            state_d       = ACCUM;
          end else begin
            drain_layer_d = drain_layer_q + 32'd1;
            drain_idx_d   = drain_idx_q + IDX_W'(1);
          end
        end else begin
          drain_row_d = drain_row_q + 32'd1;
          drain_idx_d = drain_idx_q + IDX_W'(1);
        end
      end

      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q        <= ACCUM;
      sample_count_q <= '0;
      drain_layer_q  <= '0;
      drain_row_q    <= '0;
      drain_idx_q    <= '0;
      layer_index_q  <= '0;
      row_index_q    <= '0;
      dc_dw_q        <= '0;
      is_update_q    <= 1'b0;
      // NOTE: the entry array is reset deliberately: a reset mid-batch must not leak stale gradients.
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      sample_count_q <= sample_count_d;
      drain_layer_q  <= drain_layer_d;
      drain_row_q    <= drain_row_d;
      drain_idx_q    <= drain_idx_d;
      layer_index_q  <= layer_index_d;
      row_index_q    <= row_index_d;
      dc_dw_q        <= dc_dw_d;
      is_update_q    <= is_update_d;
      entries_q      <= entries_d;
    end
  end

  assign is_ready     = (state_q == ACCUM);
  assign layer_index  = layer_index_q;
  assign row_index    = row_index_q;
  assign dc_dw        = dc_dw_q;
  assign is_update    = is_update_q;
  assign sample_count = sample_count_q;

endmodule
